// File: rtl/sample_stream_player.sv
// sample_stream_player: replays a preloaded buffer of multi-channel signed
// samples onto a valid/ready stream. It supports one-shot and loop playback,
// a programmable issue-rate divider, abort, and done/wr_err status pulses.
// Stored words pass through bit-exact; no arithmetic is done on samples.
module sample_stream_player #(
  parameter int DATA_W   = 14,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int RATE_W   = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [CHANNELS*DATA_W-1:0]   wr_data,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         loop_mode,
  input  logic [ADDR_W:0]              length,
  input  logic [RATE_W-1:0]            rate_div,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err,
  output logic [15:0]                  loop_cnt
);

  localparam int WORD_W = CHANNELS * DATA_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Sample buffer; rd_data_reg holds the word at rd_addr_reg once primed.
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data_reg;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [RATE_W-1:0] reload_reg;
  logic [RATE_W-1:0] rate_cnt_reg;
  logic              loop_mode_reg;
  logic [15:0]       loop_cnt_reg;
  logic              out_valid_reg;
  logic              done_reg;
  logic              wr_err_reg;

  // Values captured at start.
  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W-1:0] last_addr_start;
  logic [RATE_W-1:0] reload_start;

  logic              start_ok;
  logic              slot_free;
  logic              accept;
  logic              issue;
  logic              at_last;
  logic [ADDR_W-1:0] wrap_addr;
  logic              stalled;

  assign busy      = (state_reg != ST_IDLE);
  assign start_ok  = (state_reg == ST_IDLE) && start;
  assign slot_free = !out_valid_reg || out_ready;
  assign accept    = out_valid_reg && out_ready;
  assign stalled   = out_valid_reg && !out_ready;
  assign at_last   = (rd_addr_reg == last_addr_reg);
  assign wrap_addr = at_last ? '0 : rd_addr_reg + ADDR_W'(1);
  // A word leaves the buffer only when the rate counter has expired and the
  // output register can take it; abort wins over everything.
  assign issue     = (state_reg == ST_RUN) && (rate_cnt_reg == '0) && slot_free && !abort;
  // Writes are only honoured while idle so a replay never sees a torn buffer.
  assign ram_wr_en = wr_en && !busy;

  // length=0 (or anything beyond DEPTH) plays the whole buffer; DEPTH is a
  // power of two, so the last address is then all ones.
  assign len_m1          = length - (ADDR_W+1)'(1);
  assign last_addr_start = ((length == '0) || (length > DEPTH_W)) ? '1 : len_m1[ADDR_W-1:0];
  // rate_div of 0 and 1 both mean every cycle.
  assign reload_start    = (rate_div == '0) ? '0 : rate_div - RATE_W'(1);

  // Buffer write port and registered read port (one cycle read latency).
  always_ff @(posedge clk_in) begin
    if (ram_wr_en)
      mem[wr_addr] <= wr_data;
    if (ram_rd_en)
      rd_data_reg <= mem[ram_rd_addr];
  end

  // Next-state and buffer read request decoding.
  always_comb begin
    state_next  = state_reg;
    ram_rd_en   = 1'b0;
    ram_rd_addr = wrap_addr;
    case (state_reg)
      ST_IDLE: begin
        if (start)
          state_next = ST_PRIME;
      end
      ST_PRIME: begin
        // rd_addr_reg was cleared at start, so this fetches word 0.
        ram_rd_en   = 1'b1;
        ram_rd_addr = rd_addr_reg;
        state_next  = ST_RUN;
      end
      ST_RUN: begin
        if (issue) begin
          // Prefetch the following word in the same cycle so loop playback
          // runs without a bubble across the wrap.
          ram_rd_en = 1'b1;
          if (at_last && !loop_mode_reg)
            state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (busy && abort)
      state_next = ST_IDLE;
  end

  // FSM state, playback parameters, address, rate counter and loop count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= ST_IDLE;
      rd_addr_reg   <= '0;
      last_addr_reg <= '0;
      reload_reg    <= '0;
      rate_cnt_reg  <= '0;
      loop_mode_reg <= 1'b0;
      loop_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        last_addr_reg <= last_addr_start;
        reload_reg    <= reload_start;
        loop_mode_reg <= loop_mode;
        loop_cnt_reg  <= '0;
        rd_addr_reg   <= '0;
        rate_cnt_reg  <= '0;
      end else if (issue) begin
        rd_addr_reg  <= wrap_addr;
        rate_cnt_reg <= reload_reg;
        if (at_last && loop_mode_reg && (loop_cnt_reg != 16'hFFFF))
          loop_cnt_reg <= loop_cnt_reg + 16'd1;
      end else if ((state_reg == ST_RUN) && (rate_cnt_reg != '0) && !stalled) begin
        // The counter is frozen under backpressure so no word slot is lost.
        rate_cnt_reg <= rate_cnt_reg - RATE_W'(1);
      end
    end
  end

  // Output handshake flag and status pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      wr_err_reg    <= 1'b0;
    end else begin
      if (busy && abort)
        out_valid_reg <= 1'b0;
      else if (issue)
        out_valid_reg <= 1'b1;
      else if (accept)
        out_valid_reg <= 1'b0;
      done_reg   <= (state_reg == ST_DRAIN) && accept && !abort;
      wr_err_reg <= wr_en && busy;
    end
  end

  // Per-channel output registers; each lane copies its slice of the buffer
  // word unchanged and holds it after completion or abort.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [DATA_W-1:0] lane_reg;
      // Load this lane whenever a new word is issued.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
          lane_reg <= '0;
        else if (issue)
          lane_reg <= rd_data_reg[gi*DATA_W +: DATA_W];
      end
      assign out_data[gi*DATA_W +: DATA_W] = lane_reg;
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign done      = done_reg;
  assign wr_err    = wr_err_reg;
  assign loop_cnt  = loop_cnt_reg;

endmodule

// File: tb/tb_sample_stream_player.sv
// Testbench for sample_stream_player: scoreboard queue of expected words,
// filled by the stimulus process and drained by a handshake monitor.
module tb_sample_stream_player;

  localparam int DATA_W   = 14;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 1024;
  localparam int ADDR_W   = 10;
  localparam int RATE_W   = 16;
  localparam int WORD_W   = CHANNELS * DATA_W;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              start;
  logic              abort;
  logic              loop_mode;
  logic [ADDR_W:0]   length;
  logic [RATE_W-1:0] rate_div;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              wr_err;
  logic [15:0]       loop_cnt;

  sample_stream_player #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RATE_W(RATE_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .loop_mode(loop_mode), .length(length), .rate_div(rate_div),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .wr_err(wr_err), .loop_cnt(loop_cnt)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_W-1:0] exp_q[$];
  int                hs_cyc[$];
  int                hs_count   = 0;
  int                done_count = 0;
  int                done_cyc   = 0;
  logic              prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_data  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Ramp pattern: channel 0 = i, channel 1 = -i.
  function automatic logic [WORD_W-1:0] mkword(input int i);
    int neg;
    logic [WORD_W-1:0] w;
    neg = -i;
    w[DATA_W-1:0]      = i[DATA_W-1:0];
    w[WORD_W-1:DATA_W] = neg[DATA_W-1:0];
    return w;
  endfunction

  // Monitor: compares every handshake against the scoreboard and checks
  // that a stalled word holds steady.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none (cyc %0d)", out_data, cyc);
        end else begin
          logic [WORD_W-1:0] e;
          e = exp_q.pop_front();
          $display("xfer cyc=%0d data=%h exp=%h", cyc, out_data, e);
          check("word", 64'(out_data), 64'(e));
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("done_busy", 64'(busy), 64'd0);
      end
      prev_stall = out_valid && !out_ready && !abort;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_start(input int len, input int rate, input logic lm, output int s_cyc);
    s_cyc     = cyc;
    length    = len[ADDR_W:0];
    rate_div  = rate[RATE_W-1:0];
    loop_mode = lm;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n = 0;
    while (hs_count < target && n < budget) begin
      tick();
      n++;
    end
    if (hs_count < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d words expected %0d (timeout)", name, hs_count, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(busy), 64'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, b, d0;
    rst_in = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; abort = 1'b0;
    loop_mode = 1'b0; length = '0; rate_div = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    check("rst_loop_cnt", 64'(loop_cnt), 64'd0);
    rst_in = 1'b0;
    tick();

    // Preload the ramp.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = i[ADDR_W-1:0]; wr_data = mkword(i);
      tick();
    end
    wr_en = 1'b0;
    tick();

    // One-shot, length 8, every cycle.
    hs_cyc.delete(); b = hs_count; d0 = done_count;
    for (int i = 0; i < 8; i++) exp_q.push_back(mkword(i));
    do_start(8, 1, 1'b0, s);
    wait_hs(b + 8, 40, "oneshot_words");
    wait_idle(20, "oneshot_idle");
    if (hs_cyc.size() == 8) begin
      check("oneshot_first_lat", 64'(hs_cyc[0] - s), 64'd3);
      check("oneshot_last_cyc", 64'(hs_cyc[7] - s), 64'd10);
    end
    check("oneshot_done_cnt", 64'(done_count - d0), 64'd1);
    check("oneshot_done_cyc", 64'(done_cyc - s), 64'd11);

    // Loop, length 4, take 10 words then abort.
    hs_cyc.delete(); b = hs_count; d0 = done_count;
    for (int i = 0; i < 10; i++) exp_q.push_back(mkword(i % 4));
    do_start(4, 1, 1'b1, s);
    wait_hs(b + 10, 40, "loop_words");
    check("loop_cnt_2", 64'(loop_cnt), 64'd2);
    abort = 1'b1; out_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    if (hs_cyc.size() == 10) check("loop_gapless", 64'(hs_cyc[9] - hs_cyc[0]), 64'd9);
    repeat (3) tick();
    check("abort_no_done", 64'(done_count - d0), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;
    tick();

    // rate_div = 5, length 3.
    hs_cyc.delete(); b = hs_count; d0 = done_count;
    for (int i = 0; i < 3; i++) exp_q.push_back(mkword(i));
    do_start(3, 5, 1'b0, s);
    wait_hs(b + 3, 60, "rate_words");
    wait_idle(20, "rate_idle");
    if (hs_cyc.size() == 3) begin
      check("rate_first_lat", 64'(hs_cyc[0] - s), 64'd3);
      check("rate_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd5);
      check("rate_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd5);
    end
    check("rate_done_cnt", 64'(done_count - d0), 64'd1);

    // Random backpressure, length 16.
    b = hs_count; d0 = done_count;
    for (int i = 0; i < 16; i++) exp_q.push_back(mkword(i));
    do_start(16, 1, 1'b0, s);
    begin
      int n = 0;
      while (hs_count < b + 16 && n < 500) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    out_ready = 1'b1;
    check("bp_words", 64'(hs_count - b), 64'd16);
    wait_idle(20, "bp_idle");
    check("bp_done_cnt", 64'(done_count - d0), 64'd1);
    check("bp_queue", 64'(exp_q.size()), 64'd0);

    // Write and start while running must be rejected/ignored.
    b = hs_count; d0 = done_count;
    for (int i = 0; i < 16; i++) exp_q.push_back(mkword(i));
    do_start(16, 1, 1'b0, s);
    repeat (3) tick();
    wr_en = 1'b1; wr_addr = 10'd2; wr_data = 28'h0ABCDEF;
    tick();
    wr_en = 1'b0;
    check("wr_err_pulse", 64'(wr_err), 64'd1);
    start = 1'b1; length = 11'd2;
    tick();
    start = 1'b0;
    check("wr_err_clear", 64'(wr_err), 64'd0);
    wait_hs(b + 16, 60, "busy_words");
    wait_idle(20, "busy_idle");
    check("busy_done_cnt", 64'(done_count - d0), 64'd1);
    b = hs_count;
    for (int i = 0; i < 4; i++) exp_q.push_back(mkword(i));
    do_start(4, 1, 1'b0, s);
    wait_hs(b + 4, 40, "replay_words");
    wait_idle(20, "replay_idle");

    // Asynchronous reset mid-run, then full-buffer playback with length 0.
    b = hs_count;
    for (int i = 0; i < 16; i++) exp_q.push_back(mkword(i % 8));
    do_start(8, 1, 1'b1, s);
    wait_hs(b + 5, 40, "pre_reset_words");
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_wr_err", 64'(wr_err), 64'd0);
    check("arst_loop_cnt", 64'(loop_cnt), 64'd0);
    exp_q.delete();
    tick();
    rst_in = 1'b0;
    tick();
    hs_cyc.delete(); b = hs_count; d0 = done_count;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mkword(i));
    do_start(0, 1, 1'b0, s);
    wait_hs(b + DEPTH, 1200, "full_words");
    wait_idle(20, "full_idle");
    check("full_done_cnt", 64'(done_count - d0), 64'd1);
    check("full_queue", 64'(exp_q.size()), 64'd0);
    if (hs_cyc.size() == DEPTH) check("full_gapless", 64'(hs_cyc[DEPTH-1] - hs_cyc[0]), 64'(DEPTH - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_stream_player.md
# sample_stream_player

Synthesizable, parametrised multi-channel sample source that replays a preloaded buffer of signed samples into the demodulator chain (Costas loop input) at a programmable rate. It replaces file-driven stimulus with an on-chip block usable both in simulation and on hardware. It adds one-shot/loop modes, a rate divider, a valid/ready output handshake, abort and completion status.

## Interface
- DATA_W, 14, signed sample width per channel
- CHANNELS, 2, channels per buffer word; all channels play in lockstep
- DEPTH, 1024, buffer words; must be a power of two
- ADDR_W, $clog2(DEPTH), address width
- RATE_W, 16, width of rate divider input
- clk_in  in  1  system clock (100 MHz)
- rst_in  in  1  asynchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  buffer write address
- wr_data  in  CHANNELS*DATA_W  write word; channel 0 in LSBs
- start  in  1  single-cycle playback request
- abort  in  1  single-cycle stop request
- loop_mode  in  1  0 = one-shot, 1 = repeat until abort; sampled at start
- length  in  ADDR_W+1  words to play, 1..DEPTH; 0 treated as DEPTH; sampled at start
- rate_div  in  RATE_W  issue one word per rate_div cycles; 0 and 1 both mean every cycle; sampled at start
- out_data  out  CHANNELS*DATA_W  sample word, two's complement
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on one-shot completion
- wr_err  out  1  one-cycle pulse when wr_en is rejected (busy)
- loop_cnt  out  16  completed passes in loop mode, saturating

## Operation
- Buffer: inferred single-clock RAM; synchronous read with 1-cycle latency. Writes are accepted only when busy=0; wr_en while busy=1 is dropped and pulses wr_err the next cycle.
- FSM states: IDLE, PRIME, RUN, DRAIN.
  - IDLE: start=1 latches length/rate_div/loop_mode, clears loop_cnt, sets rd_addr=0 and enters PRIME.
  - PRIME: issues the RAM read of address 0, then enters RUN.
  - RUN: when the rate counter expires and the output slot is free (out_valid=0 or out_ready=1), the read word is loaded into out_data with out_valid=1, and the next address is issued.
  - Address wrap: after address length-1 the address returns to 0.
    - Loop mode: loop_cnt increments, saturating at 16'hFFFF.
    - One-shot: the FSM enters DRAIN after the last word is loaded.
  - DRAIN: waits until the final word is accepted, then pulses done and returns to IDLE.
- Rate counter: loads rate_div-1 on each issued word and counts down; a word may be issued only when the counter reads 0. The counter is held while stalled, so no words are skipped under backpressure.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid hold stable and rd_addr does not advance.
- abort: from any non-IDLE state, go to IDLE next cycle; clear out_valid; no done pulse. Takes priority over a simultaneous start, accept or wrap.
- start while busy: ignored.
- out_data after completion or abort holds its last value; only out_valid clears.
- No arithmetic on samples; bit-exact passthrough of stored words.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, done=0, wr_err=0, loop_cnt=0, FSM=IDLE.
- Latency: start at cycle 0 gives busy=1 at cycle 1 and the first out_valid=1 at cycle 3 with word 0 (PRIME, then RAM read, then output register).
- Throughput with rate_div<=1 and out_ready=1: one word per cycle, including across the loop wrap (no bubble).
- A word written at cycle n is readable by a start at cycle n+1.
- done: asserted exactly one cycle, the cycle after the last word's handshake; busy=0 in that same cycle.

## Test plan
- Preload DEPTH=1024 words with ramp value i (ch0) and -i (ch1); one-shot, length=8, rate_div=1, out_ready=1 -> 8 consecutive words 0..7 / 0..-7 starting 3 cycles after start, done one cycle after word 7, busy=0.
- Loop, length=4, run 10 words -> sequence 0,1,2,3,0,1,… with no gaps; loop_cnt=2 after 3rd wrap-pending; abort -> out_valid=0 next cycle, no done.
- rate_div=5, length=3 -> out_valid handshakes exactly 5 cycles apart.
- Random out_ready toggling (50%) for length=16 -> all 16 words delivered in order, none duplicated or skipped, out_data stable while stalled.
- wr_en during RUN -> wr_err pulse, buffer content unchanged on next replay; start during RUN ignored.
- Assert rst_in mid-RUN -> all outputs reset values asynchronously, FSM IDLE; length=0 start afterwards plays all 1024 words.
